halfword_narrower: RTL and testbench
====================================

# halfword_narrower

Saturating 32-to-16-bit signed narrowing unit; the inverse of the datapath's 16-to-32 immediate sign extension. It sits on the store/result path ahead of 16-bit consumers such as halfword memory and the DSP scratch bus. Each 32-bit word is checked for signed-16 representability, then either saturated or truncated. The result is emitted over a valid/ready stream with a registered, skid-buffered input ready. Overflow events are counted in a sticky, saturating counter.

## Interface
- IN_W, 32, input word width
- OUT_W, 16, output width; must be less than IN_W
- CNT_W, 8, overflow counter width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  unit can accept a word; registered
- in_data  in  IN_W  signed input word
- sat_en  in  1  1 = saturate, 0 = truncate; sampled with in_data on accept
- out_valid  out  1  output halfword valid
- out_ready  in  1  downstream accepts
- out_data  out  OUT_W  narrowed result
- out_ovf  out  1  this result was out of signed-OUT_W range
- ovf_count  out  CNT_W  number of overflowing words accepted; sticks at all-ones
- ovf_clear  in  1  synchronous clear of ovf_count

## Operation
- Representable: in_data[IN_W-1:OUT_W-1] all equal. Otherwise ovf = 1.
- Result when sat_en = 1 and ovf = 1:
  - 0x7FFF if in_data[IN_W-1] = 0
  - 0x8000 if in_data[IN_W-1] = 1
- Result in all other cases: in_data[OUT_W-1:0].
- Accept when in_valid && in_ready. Transfer when out_valid && out_ready.
- Storage is an output register plus one skid register.
- Accepted word goes to the output register if it is empty or being drained this cycle; otherwise it goes to the skid register.
- in_ready = !skid_valid, registered.
- When the output register drains and the skid is full, the skid moves to the output register and the skid is freed.
- FSM states:
  - EMPTY: out_valid = 0, in_ready = 1
  - ONE: out_valid = 1, in_ready = 1
  - FULL: out_valid = 1, in_ready = 0
- FSM transitions:
  - EMPTY to ONE on accept.
  - ONE to FULL on accept without transfer.
  - ONE to EMPTY on transfer without accept.
  - ONE stays ONE on accept together with transfer.
  - FULL to ONE on transfer.
- ovf_count increments by 1 when an accepted word has ovf = 1, independent of sat_en. It holds at 2^CNT_W-1.
- ovf_clear has priority over an increment in the same cycle; the result is 0.
- Input and output data order is strictly preserved.

## Timing
- Reset values: out_valid = 0, in_ready = 1, out_data = 0, out_ovf = 0, ovf_count = 0, FSM = EMPTY. Skid contents are cleared.
- Latency: a word accepted on edge N is on out_data/out_ovf after edge N with out_valid = 1.
- Throughput: one word per cycle while out_ready = 1.
- out_data/out_ovf hold stable while out_valid && !out_ready.
- in_ready deasserts the cycle after the skid fills. It is never combinationally dependent on out_ready.
- Reset mid-operation: all buffered words are discarded immediately (asynchronous). The first accept is allowed on the first edge after rst_n rises.
- Simultaneous accept and transfer in FULL cannot occur, because in_ready = 0.

## Structure
- Package narrow_pkg holds:
  - IN_W/OUT_W default constants
  - SAT_MAX/SAT_MIN constants
  - FSM state enum
  - pure function for the narrow-and-flag computation
- Sub-module skid_buffer: generic width-parameterized 2-entry valid/ready buffer carrying {ovf, data}.
- Top level holds the narrowing function and the ovf_count logic.

## Test plan
- sat_en = 1, in_data 0x00001234, out_ready = 1 → next cycle out_data 0x1234, out_ovf 0, ovf_count 0.
- sat_en = 1, in_data 0x00018000 then 0xFFFF7FFF → out_data 0x7FFF then 0x8000, both out_ovf 1, ovf_count 2.
- sat_en = 0, in_data 0x00018000 → out_data 0x8000, out_ovf 1. Boundary 0xFFFF8000 → out_data 0x8000, out_ovf 0.
- Backpressure: out_ready = 0, stream 3 words.
  - First two are accepted.
  - in_ready falls after the second accept; the third is held.
  - With out_ready = 1 the three words emerge in order, one per cycle, with no loss or duplication.
- Counter:
  - 300 overflowing words with CNT_W = 8 → ovf_count sticks at 255.
  - ovf_clear asserted with a concurrent overflow → ovf_count 0.
- Reset: assert rst_n = 0 asynchronously while in FULL → out_valid and ovf_count drop immediately and in_ready = 1. No stale word appears after release.

Source files
------------

// File: rtl/narrow_pkg.sv
// Shared widths, saturation constants, FSM states and the narrow-and-flag function
// for the halfword narrowing unit.
package narrow_pkg;

    localparam int unsigned IN_W  = 32;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned HI_W  = IN_W - OUT_W + 1;

    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_e;

    typedef struct packed {
        logic             ovf;
        logic [OUT_W-1:0] data;
    } narrow_t;

    // Representable iff the top HI_W bits are all equal; saturate or truncate otherwise.
    function automatic narrow_t narrow_word(input logic [IN_W-1:0] d, input logic sat);
        narrow_t          r;
        logic [HI_W-1:0]  hi;
        hi    = d[IN_W-1:OUT_W-1];
        r.ovf = ~((&hi) | ~(|hi));
        if (sat && r.ovf) begin
            r.data = d[IN_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            r.data = d[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/halfword_narrower_if.sv
// Stream and control bundle of the halfword narrower.
interface halfword_narrower_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_clear;

    modport master (
        output in_valid, in_data, sat_en, out_ready, ovf_clear,
        input  in_ready, out_valid, out_data, out_ovf, ovf_count
    );

    modport slave (
        input  in_valid, in_data, sat_en, out_ready, ovf_clear,
        output in_ready, out_valid, out_data, out_ovf, ovf_count
    );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready buffer: output register plus one skid register,
// with in_ready decoded from the state register only.
module skid_buffer
    import narrow_pkg::*;
#(
    parameter int unsigned W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    state_e       state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         xfer;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_q;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    // Incoming word lands in the output register when it is empty or draining, else in the skid.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    out_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    out_d   = skid_q;
                    skid_d  = '0;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

endmodule

// File: rtl/halfword_narrower.sv
// Saturating 32-to-16 signed narrowing unit with skid-buffered stream output
// and a sticky saturating overflow counter.
module halfword_narrower
    import narrow_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    halfword_narrower_if.slave   bus
);

    localparam int unsigned BUF_W = $bits(narrow_t);

    narrow_t          nar_c;
    narrow_t          buf_out;
    logic             accept;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    always_comb nar_c = narrow_word(bus.in_data, bus.sat_en);

    assign accept = bus.in_valid && bus.in_ready;

    skid_buffer #(.W(BUF_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (nar_c),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (buf_out)
    );

    assign bus.out_data  = buf_out.data;
    assign bus.out_ovf   = buf_out.ovf;
    assign bus.ovf_count = ovf_count_q;

    // Clear wins over a same-cycle increment; the count parks at all-ones.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (bus.ovf_clear) begin
            ovf_count_d = '0;
        end else if (accept && nar_c.ovf && (ovf_count_q != '1)) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

endmodule

// File: tb/tb_halfword_narrower.sv
// Scoreboard bench for halfword_narrower: directed words with hand-computed results.
module tb_halfword_narrower;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [16:0] exp_q[$];

    halfword_narrower_if bus ();

    halfword_narrower dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one word; push its expected result when it will be accepted on the next edge.
    task automatic send(input logic [31:0] d, input logic s, input logic [15:0] ed, input logic eo);
        logic ok;
        ok          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.sat_en   = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back({eo, ed});
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word 0x%0h never accepted", d);
        end
    endtask

    // Monitor: every presented output is compared against the scoreboard front.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got data 0x%0h ovf %0d with nothing expected",
                         bus.out_data, bus.out_ovf);
            end else begin
                if (bus.out_ready) e = exp_q.pop_front();
                else               e = exp_q[0];
                chk("out_data", 32'(bus.out_data), 32'(e[15:0]));
                chk("out_ovf",  32'(bus.out_ovf),  32'(e[16]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sat_en    = 1'b0;
        bus.out_ready = 1'b0;
        bus.ovf_clear = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
        chk("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Representable word, latency of one edge
        bus.out_ready = 1'b1;
        send(32'h0000_1234, 1'b1, 16'h1234, 1'b0);
        chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
        idle(2);
        chk("count_after_clean", 32'(bus.ovf_count), 32'd0);

        // Saturation both directions, back to back
        send(32'h0001_8000, 1'b1, 16'h7FFF, 1'b1);
        send(32'hFFFF_7FFF, 1'b1, 16'h8000, 1'b1);
        idle(3);
        chk("count_after_sat", 32'(bus.ovf_count), 32'd2);

        // Truncation and boundaries
        send(32'h0001_8000, 1'b0, 16'h8000, 1'b1);
        send(32'hFFFF_8000, 1'b1, 16'h8000, 1'b0);
        send(32'h0000_7FFF, 1'b1, 16'h7FFF, 1'b0);
        send(32'h8000_0000, 1'b1, 16'h8000, 1'b1);
        send(32'h1234_5678, 1'b0, 16'h5678, 1'b1);
        idle(3);
        chk("count_after_trunc", 32'(bus.ovf_count), 32'd5);

        // Backpressure: two words fill the buffer, the third waits
        bus.out_ready = 1'b0;
        send(32'h0000_0001, 1'b1, 16'h0001, 1'b0);
        send(32'h0000_FFFF, 1'b1, 16'h7FFF, 1'b1);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        fork
            send(32'hFFFF_FFFE, 1'b1, 16'hFFFE, 1'b0);
            begin
                idle(3);
                chk("held_in_ready",  32'(bus.in_ready),  32'd0);
                chk("held_out_valid", 32'(bus.out_valid), 32'd1);
                bus.out_ready = 1'b1;
            end
        join
        idle(4);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        chk("count_after_bp", 32'(bus.ovf_count), 32'd6);

        // Counter saturation
        bus.ovf_clear = 1'b1;
        idle(1);
        bus.ovf_clear = 1'b0;
        chk("count_cleared", 32'(bus.ovf_count), 32'd0);
        for (int i = 0; i < 300; i++) begin
            send(32'h0001_0000, 1'b0, 16'h0000, 1'b1);
        end
        idle(3);
        chk("count_sticky", 32'(bus.ovf_count), 32'd255);

        // Clear beats a concurrent overflow
        bus.ovf_clear = 1'b1;
        send(32'h7FFF_FFFF, 1'b1, 16'h7FFF, 1'b1);
        bus.ovf_clear = 1'b0;
        chk("clear_priority", 32'(bus.ovf_count), 32'd0);
        send(32'hF000_0000, 1'b1, 16'h8000, 1'b1);
        idle(3);
        chk("count_after_clear", 32'(bus.ovf_count), 32'd1);

        // Asynchronous reset while FULL
        bus.out_ready = 1'b0;
        send(32'h0000_0011, 1'b1, 16'h0011, 1'b0);
        send(32'h0000_0022, 1'b1, 16'h0022, 1'b0);
        chk("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid_rst_ovf_count", 32'(bus.ovf_count), 32'd0);
        chk("mid_rst_out_data",  32'(bus.out_data),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        idle(5);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        send(32'h0000_0042, 1'b1, 16'h0042, 1'b0);
        idle(3);
        chk("post_rst_count", 32'(bus.ovf_count), 32'd0);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
